// File: rtl/sap1_pkg.sv
// Shared SAP-1 constants: opcodes, control-word bit positions, the ring-counter
// state type and the named control words the sequencer emits.
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int CW_CP = 11;
    localparam int CW_EP = 10;
    localparam int CW_LM = 9;
    localparam int CW_CE = 8;
    localparam int CW_LI = 7;
    localparam int CW_EI = 6;
    localparam int CW_LA = 5;
    localparam int CW_EA = 4;
    localparam int CW_SU = 3;
    localparam int CW_EU = 2;
    localparam int CW_LB = 1;
    localparam int CW_LO = 0;

    // CE and Ei are active-low, so the quiet word keeps both high.
    localparam logic [11:0] IDLE_WORD = 12'h140;
    localparam logic [11:0] FETCH_T1  = 12'h740;
    localparam logic [11:0] FETCH_T2  = 12'h940;
    localparam logic [11:0] FETCH_T3  = 12'h0C0;
    localparam logic [11:0] ADDR_T4   = 12'h300;
    localparam logic [11:0] LDA_T5    = 12'h060;
    localparam logic [11:0] LDB_T5    = 12'h042;
    localparam logic [11:0] ADD_T6    = 12'h164;
    localparam logic [11:0] SUB_T6    = 12'h16C;
    localparam logic [11:0] OUT_T4    = 12'h151;

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_e;

    // Execute-phase word; step 0..2 selects T4..T6.
    function automatic logic [11:0] exec_word(input logic [3:0] op, input logic [1:0] step);
        logic [11:0] w;
        w = IDLE_WORD;
        unique case (op)
            OP_LDA: w = (step == 2'd0) ? ADDR_T4 : (step == 2'd1) ? LDA_T5 : IDLE_WORD;
            OP_ADD: w = (step == 2'd0) ? ADDR_T4 : (step == 2'd1) ? LDB_T5 : ADD_T6;
            OP_SUB: w = (step == 2'd0) ? ADDR_T4 : (step == 2'd1) ? LDB_T5 : SUB_T6;
            OP_OUT: w = (step == 2'd0) ? OUT_T4 : IDLE_WORD;
            default: w = IDLE_WORD;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sap1_exec_core_if.sv
// Bus-side signals of the SAP-1 execution core; the core is the slave, the
// surrounding computer (IR, B register, bus mux) is the master.
interface sap1_exec_core_if;
    logic [3:0]  opcode;
    logic [7:0]  bus_in;
    logic [7:0]  b_in;
    logic [11:0] con_word;
    logic [7:0]  acc_out;
    logic [7:0]  alu_out;
    logic [5:0]  tstate;
    logic        halted;

    modport master (
        output opcode, bus_in, b_in,
        input  con_word, acc_out, alu_out, tstate, halted
    );

    modport slave (
        input  opcode, bus_in, b_in,
        output con_word, acc_out, alu_out, tstate, halted
    );
endinterface

// File: rtl/sap1_alu.sv
// Combinational 8-bit add/subtract; results wrap modulo 256, no flags.
module sap1_alu (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       sub,
    output logic [7:0] y
);
    always_comb begin
        y = sub ? (a - b) : (a + b);
    end
endmodule

// File: rtl/sap1_exec_core.sv
// SAP-1 control sequencer (six-state ring counter + opcode decode), accumulator
// and ALU. Everything else on the SAP-1 bus lives outside this block.
module sap1_exec_core
    import sap1_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    sap1_exec_core_if.slave        core_if
);

    tstate_e     tstate_q, tstate_d;
    logic [7:0]  acc_q, acc_d;
    logic        halted_q, halted_d;
    logic [11:0] cw;
    logic [7:0]  alu_y;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tstate_q <= T1;
            acc_q    <= 8'h00;
            halted_q <= 1'b0;
        end else begin
            tstate_q <= tstate_d;
            acc_q    <= acc_d;
            halted_q <= halted_d;
        end
    end

    // Once halted the ring counter parks on T5 until reset.
    always_comb begin
        tstate_d = tstate_q;
        halted_d = halted_q;
        if (!halted_q) begin
            unique case (tstate_q)
                T1:      tstate_d = T2;
                T2:      tstate_d = T3;
                T3:      tstate_d = T4;
                T4:      tstate_d = T5;
                T5:      tstate_d = T6;
                T6:      tstate_d = T1;
                default: tstate_d = T1;
            endcase
            if (tstate_q == T4 && core_if.opcode == OP_HLT) begin
                halted_d = 1'b1;
            end
        end
    end

    always_comb begin
        cw = IDLE_WORD;
        if (!halted_q) begin
            unique case (tstate_q)
                T1:      cw = FETCH_T1;
                T2:      cw = FETCH_T2;
                T3:      cw = FETCH_T3;
                T4:      cw = exec_word(core_if.opcode, 2'd0);
                T5:      cw = exec_word(core_if.opcode, 2'd1);
                T6:      cw = exec_word(core_if.opcode, 2'd2);
                default: cw = IDLE_WORD;
            endcase
        end
    end

    always_comb begin
        acc_d = cw[CW_LA] ? core_if.bus_in : acc_q;
    end

    sap1_alu u_alu (
        .a   (acc_q),
        .b   (core_if.b_in),
        .sub (cw[CW_SU]),
        .y   (alu_y)
    );

    assign core_if.con_word = cw;
    assign core_if.acc_out  = acc_q;
    assign core_if.alu_out  = alu_y;
    assign core_if.tstate   = tstate_q;
    assign core_if.halted   = halted_q;

endmodule

// File: tb/tb_sap1_exec_core.sv
// Scoreboard bench for sap1_exec_core: stimulus pushes hand-computed per-cycle
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_sap1_exec_core;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sap1_exec_core_if dut_if ();

    sap1_exec_core dut (
        .clk     (clk),
        .rst     (rst),
        .core_if (dut_if.slave)
    );

    typedef struct {
        string       tag;
        logic [11:0] cw;
        logic [5:0]  ts;
        logic [7:0]  acc;
        logic        hlt;
        bit          chk_alu;
        logic [7:0]  alu;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic [7:0] acc_m = 8'h00;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents a new state; compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.tag, ".con_word"}, int'(dut_if.con_word), int'(e.cw));
                check({e.tag, ".tstate"},   int'(dut_if.tstate),   int'(e.ts));
                check({e.tag, ".acc_out"},  int'(dut_if.acc_out),  int'(e.acc));
                check({e.tag, ".halted"},   int'(dut_if.halted),   int'(e.hlt));
                if (e.chk_alu) check({e.tag, ".alu_out"}, int'(dut_if.alu_out), int'(e.alu));
            end
        end
    end

    function automatic logic [11:0] ref_cw(input logic [3:0] op, input int t);
        logic [11:0] w;
        w = 12'h140;
        if (t == 1) w = 12'h740;
        else if (t == 2) w = 12'h940;
        else if (t == 3) w = 12'h0C0;
        else begin
            case (op)
                4'h0: w = (t == 4) ? 12'h300 : (t == 5) ? 12'h060 : 12'h140;
                4'h1: w = (t == 4) ? 12'h300 : (t == 5) ? 12'h042 : 12'h164;
                4'h2: w = (t == 4) ? 12'h300 : (t == 5) ? 12'h042 : 12'h16C;
                4'hE: w = (t == 4) ? 12'h151 : 12'h140;
                default: w = 12'h140;
            endcase
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One instruction: bus_v is the bus value at T5 (LDA operand), res is the
    // hand-computed ALU result driven on the bus at T6. rst_step>0 pulses reset
    // during that T-state and abandons the instruction.
    task automatic run_instr(input string tag, input logic [3:0] op, input logic [7:0] b,
                             input logic [7:0] bus_v, input logic [7:0] res, input int rst_step);
        exp_t e;
        int   last;
        last = (op == 4'hF) ? 4 : 6;
        for (int t = 1; t <= last; t++) begin
            dut_if.opcode = op;
            dut_if.b_in   = b;
            dut_if.bus_in = (t == 6) ? res : bus_v;
            if (t == rst_step) rst = 1'b0;
            e.tag     = $sformatf("%s.T%0d", tag, t);
            e.cw      = ref_cw(op, t);
            e.ts      = 6'(1 << (t - 1));
            e.acc     = acc_m;
            e.hlt     = 1'b0;
            e.chk_alu = (t == 6) && (op == 4'h1 || op == 4'h2);
            e.alu     = res;
            sb_q.push_back(e);
            tick();
            if (t == rst_step) begin
                rst   = 1'b1;
                acc_m = 8'h00;
                $display("instr %s op=%h reset at T%0d acc=%02h", tag, op, t, acc_m);
                return;
            end
            if (t == 5 && op == 4'h0) acc_m = bus_v;
            if (t == 6 && (op == 4'h1 || op == 4'h2)) acc_m = res;
        end
        $display("instr %s op=%h acc=%02h", tag, op, acc_m);
    endtask

    initial begin
        exp_t e;
        dut_if.opcode = 4'h0;
        dut_if.bus_in = 8'h00;
        dut_if.b_in   = 8'h00;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        acc_m = 8'h00;

        run_instr("idle0",  4'h0, 8'h00, 8'h00, 8'h00, 0);
        run_instr("idle1",  4'h0, 8'h00, 8'h00, 8'h00, 0);
        run_instr("lda1c",  4'h0, 8'h00, 8'h1C, 8'h00, 0);
        run_instr("add0e",  4'h1, 8'h0E, 8'hAA, 8'h2A, 0);
        run_instr("lda05",  4'h0, 8'h00, 8'h05, 8'h00, 0);
        run_instr("sub07",  4'h2, 8'h07, 8'hAA, 8'hFE, 0);
        run_instr("ldaf0",  4'h0, 8'h00, 8'hF0, 8'h00, 0);
        run_instr("add20",  4'h1, 8'h20, 8'h55, 8'h10, 0);
        run_instr("out",    4'hE, 8'h00, 8'h99, 8'h99, 0);
        run_instr("nop5",   4'h5, 8'h00, 8'h77, 8'h77, 0);
        run_instr("hlt",    4'hF, 8'h00, 8'h00, 8'h00, 0);

        for (int i = 0; i < 20; i++) begin
            dut_if.opcode = (i % 2 == 0) ? 4'h0 : 4'h1;
            dut_if.bus_in = 8'hC3;
            e.tag = $sformatf("halt%0d", i);
            e.cw = 12'h140; e.ts = 6'b010000; e.acc = acc_m; e.hlt = 1'b1;
            e.chk_alu = 1'b0; e.alu = 8'h00;
            sb_q.push_back(e);
            tick();
        end
        $display("instr halted 20 cycles acc=%02h", acc_m);

        rst = 1'b0;
        dut_if.bus_in = 8'h55;
        tick();
        rst = 1'b1;
        acc_m = 8'h00;

        run_instr("lda33",  4'h0, 8'h00, 8'h33, 8'h00, 0);
        run_instr("ldarst", 4'h0, 8'h00, 8'h77, 8'h00, 5);
        run_instr("nopend", 4'h7, 8'h00, 8'h00, 8'h00, 0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sap1_exec_core.md
# sap1_exec_core

Execution core of the SAP-1 8-bit computer: a six-state control sequencer, an 8-bit accumulator and an add/subtract ALU. It decodes the instruction-register opcode into the 12-bit control word that drives every SAP-1 register and bus driver. It also holds the accumulator and computes A±B for the shared 8-bit bus. Program counter, MAR, RAM, IR, register B, output register and the bus multiplexer sit outside this block.

## Interface
- No parameters; all widths are fixed.
- `clk` — input, 1 — single system clock; all state changes on its rising edge.
- `rst` — input, 1 — reset, synchronous, active-low.
- `opcode` — input, 4 — IR[7:4]; must be stable from T4 to T6.
- `bus_in` — input, 8 — shared bus value; the accumulator loads it.
- `b_in` — input, 8 — register B contents; ALU operand B.
- `con_word` — output, 12 — {Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo}, bit 11 down to bit 0.
- `acc_out` — output, 8 — accumulator contents; ALU operand A.
- `alu_out` — output, 8 — combinational ALU result.
- `tstate` — output, 6 — one-hot ring counter; bit0 = T1.
- `halted` — output, 1 — high after HLT executes.

## Operation
- Control-word polarity:
  - CE and Ei are active-low.
  - All other bits are active-high.
  - Idle word = 0x140 (CE=1, Ei=1, all others 0).
- Fetch cycle, same for every opcode:
  - T1 = 0x740 (Ep, Lm)
  - T2 = 0x940 (Cp)
  - T3 = 0x0C0 (CE low, Li)
- Execute cycle:
  - LDA 0000: T4 0x300 (Ei low, Lm), T5 0x060 (CE low, La), T6 0x140.
  - ADD 0001: T4 0x300, T5 0x042 (CE low, Lb), T6 0x164 (Eu, La).
  - SUB 0010: T4 0x300, T5 0x042, T6 0x16C (Su, Eu, La).
  - OUT 1110: T4 0x151 (Ea, Lo), T5 0x140, T6 0x140.
  - HLT 1111: T4 0x140, T5 0x140, T6 0x140; `halted` is set at the end of T4.
  - Any other opcode is a NOP: 0x140 for T4 through T6.
- `con_word` is a pure combinational decode of `tstate`, `opcode` and `halted`.
- While `halted` = 1:
  - `con_word` = 0x140.
  - The ring counter holds.
- ALU:
  - Su=0: `alu_out` = acc + b_in, modulo 256.
  - Su=1: `alu_out` = acc − b_in, two's complement, modulo 256.
  - No carry or flag outputs.
  - `alu_out` is always driven. Eu only tells the external bus mux to select it.
- Accumulator:
  - Loads `bus_in` on a rising edge when La=1.
  - Otherwise it holds its value.
  - Ea only signals the external mux; it does not change `acc_out`.

## Timing
- Reset, synchronous, active-low, sampled on the rising edge:
  - `tstate` = 000001 (T1).
  - Accumulator = 0x00.
  - `halted` = 0.
  - `con_word` = 0x740 on the cycle after reset is sampled.
  - Reset overrides any in-progress instruction and HLT.
- Ring counter advances one state per clock: T1→T2→…→T6→T1.
  - One instruction takes exactly 6 clocks.
  - There is no early termination.
- Accumulator load latency:
  - The value is visible on `acc_out` the cycle after the La edge.
  - For ADD/SUB, the T6 edge captures the ALU result computed from the pre-edge acc.
- `halted` rises on the T4→T5 edge of HLT.
  - The counter freezes at T5 and stays there until reset.
- Simultaneous La and reset: reset wins; acc = 0.

## Structure
- Package `sap1_pkg` holds:
  - Opcode constants: LDA, ADD, SUB, OUT, HLT.
  - Control-word bit-index constants.
  - Named control-word constants: FETCH_T1..T3, IDLE_WORD.
- Natural sub-module `sap1_alu`: combinational add/subtract.
- The sequencer and accumulator live inline in `sap1_exec_core`.

## Test plan
- Reset, then 3 idle cycles with opcode=0000 → con_word sequence:
  - cycles 1–3: 0x740, 0x940, 0x0C0
  - cycles 4–6: 0x300, 0x060, 0x140
  - then repeats.
- LDA with bus_in=0x1C on T5 → acc_out=0x1C in the following cycle.
- acc=0x1C, b_in=0x0E, opcode ADD → T6 word 0x164, alu_out=0x2A, acc=0x2A after the T6 edge.
- Arithmetic wrap:
  - SUB with acc=0x05, b_in=0x07 → T6 word 0x16C, acc=0xFE.
  - ADD with acc=0xF0, b_in=0x20 → acc=0x10.
- OUT → T4 word 0x151, acc unchanged. Undefined opcode 0101 → T4 to T6 all 0x140.
- HLT → halted=1 after T4, con_word stuck at 0x140 for 20 cycles. Then rst=0 for one edge → T1, con_word 0x740, halted=0, acc=0x00.
